// File: rtl/pio_irq_pkg.sv
// Shared definitions for the pio_irq_ctrl register file: word addresses and
// the register address type used by the Avalon-MM slave decode.
package pio_irq_pkg;

  typedef logic [2:0] reg_addr_t;

  localparam reg_addr_t ADDR_DATA_IN  = 3'd0;
  localparam reg_addr_t ADDR_DATA_OUT = 3'd1;
  localparam reg_addr_t ADDR_IRQ_MASK = 3'd2;
  localparam reg_addr_t ADDR_EDGE_CAP = 3'd3;
  localparam reg_addr_t ADDR_EDGE_POL = 3'd4;
  localparam reg_addr_t ADDR_TSTAMP   = 3'd5;

endpackage

// File: rtl/pio_debounce.sv
// Single-bit input conditioner: SYNC_STAGES-deep synchroniser followed by a
// debounce counter. The stable level only follows the synchronised input
// once it has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module pio_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q;
  logic                   stable_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign stable = stable_q;

  // Shift the raw asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // Count consecutive disagreeing samples; accept the new level on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (synced == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q    <= '0;
      stable_q <= ~stable_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pio_irq_ctrl.sv
// Parametrised PIO with Avalon-MM slave: output register, debounced inputs,
// polarity-selectable edge capture and a maskable level interrupt.
// Optional cycle timestamp of the first captured edge: define PIO_IRQ_TSTAMP_EN.
module pio_irq_ctrl
  import pio_irq_pkg::*;
#(
  parameter int unsigned IN_WIDTH        = 4,
  parameter int unsigned OUT_WIDTH       = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned OUT_RESET_VAL   = 0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  switches_export,
  output logic [OUT_WIDTH-1:0] leds_export
);

  reg_addr_t            addr;
  logic [IN_WIDTH-1:0]  stable;
  logic [IN_WIDTH-1:0]  stable_prev_q;
  logic [IN_WIDTH-1:0]  set_vec;
  logic [IN_WIDTH-1:0]  w1c;
  logic [IN_WIDTH-1:0]  mask_q;
  logic [IN_WIDTH-1:0]  pol_q;
  logic [IN_WIDTH-1:0]  cap_q;
  logic [IN_WIDTH-1:0]  cap_d;
  logic [OUT_WIDTH-1:0] out_q;
  logic                 irq_q;
  logic [31:0]          rd_mux;
  logic [31:0]          readdata_q;
  logic [31:0]          tstamp_rd;
  logic                 unused_wdata;

  assign addr         = reg_addr_t'(avs_address);
  assign leds_export  = out_q;
  assign irq          = irq_q;
  assign avs_readdata = readdata_q;
  // Upper write-data bits are architecturally ignored.
  assign unused_wdata = ^avs_writedata;

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_in
    pio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .din   (switches_export[i]),
      .stable(stable[i])
    );
  end

  // Qualify debounced edges by polarity and merge with write-1-to-clear (set wins).
  always_comb begin
    set_vec = (stable & ~stable_prev_q & ~pol_q) | (~stable & stable_prev_q & pol_q);
    w1c     = '0;
    if (avs_write && (addr == ADDR_EDGE_CAP)) begin
      w1c = avs_writedata[IN_WIDTH-1:0];
    end
    cap_d = (cap_q & ~w1c) | set_vec;
  end

  // Register file, edge history and registered interrupt.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_q         <= OUT_WIDTH'(OUT_RESET_VAL);
      mask_q        <= '0;
      pol_q         <= '0;
      cap_q         <= '0;
      stable_prev_q <= '0;
      irq_q         <= 1'b0;
    end else begin
      if (avs_write) begin
        case (addr)
          ADDR_DATA_OUT: out_q  <= avs_writedata[OUT_WIDTH-1:0];
          ADDR_IRQ_MASK: mask_q <= avs_writedata[IN_WIDTH-1:0];
          ADDR_EDGE_POL: pol_q  <= avs_writedata[IN_WIDTH-1:0];
          default: ;
        endcase
      end
      cap_q         <= cap_d;
      stable_prev_q <= stable;
      irq_q         <= |(cap_q & mask_q);
    end
  end

`ifdef PIO_IRQ_TSTAMP_EN
  logic [31:0] cycle_q;
  logic [31:0] tstamp_q;

  // Free-running cycle counter; latch it on the first edge into an empty EDGE_CAP.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cycle_q  <= '0;
      tstamp_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if ((cap_q == '0) && (set_vec != '0)) begin
        tstamp_q <= cycle_q;
      end
    end
  end

  assign tstamp_rd = tstamp_q;
`else
  assign tstamp_rd = '0;
`endif

  // Read decode; unimplemented addresses and bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DATA_IN:  rd_mux = 32'(stable);
      ADDR_DATA_OUT: rd_mux = 32'(out_q);
      ADDR_IRQ_MASK: rd_mux = 32'(mask_q);
      ADDR_EDGE_CAP: rd_mux = 32'(cap_q);
      ADDR_EDGE_POL: rd_mux = 32'(pol_q);
      ADDR_TSTAMP:   rd_mux = tstamp_rd;
      default:       rd_mux = '0;
    endcase
  end

  // Registered read data, held while no read is in progress.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      readdata_q <= '0;
    end else if (avs_read) begin
      readdata_q <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pio_irq_ctrl.sv
// Self-checking bench for pio_irq_ctrl: directed scenarios followed by a
// randomized phase compared every cycle against a behavioural model.
module tb_pio_irq_ctrl;

  localparam int IW  = 4;
  localparam int OW  = 4;
  localparam int SS  = 2;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          irq;
  logic [IW-1:0] sw = '0;
  logic [OW-1:0] leds;

  int n_checks = 0;
  int n_err = 0;

  pio_irq_ctrl #(
    .IN_WIDTH       (IW),
    .OUT_WIDTH      (OW),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DEB),
    .OUT_RESET_VAL  (0)
  ) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .avs_address    (avs_address),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .irq            (irq),
    .switches_export(sw),
    .leds_export    (leds)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [IW-1:0] m_pipe [SS];
  logic [IW-1:0] m_stable, m_prev, m_mask, m_pol, m_cap;
  logic [OW-1:0] m_out;
  logic          m_irq;
  logic [31:0]   m_rd, m_cnt, m_ts;
  int            m_run [IW];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SS; s++) m_pipe[s] = '0;
    for (int b = 0; b < IW; b++) m_run[b] = 0;
    m_stable = '0; m_prev = '0; m_mask = '0; m_pol = '0; m_cap = '0;
    m_out = '0; m_irq = 1'b0; m_rd = '0; m_cnt = '0; m_ts = '0;
  endtask

  function automatic logic [31:0] reg_model(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_stable);
      3'd1:    return 32'(m_out);
      3'd2:    return 32'(m_mask);
      3'd3:    return 32'(m_cap);
      3'd4:    return 32'(m_pol);
      3'd5:    return m_ts;
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge: advance the model with the inputs present at the edge.
  task automatic tick();
    logic [IW-1:0] set_v;
    logic [IW-1:0] clr;
    logic [IW-1:0] seen;
    @(posedge clk);
    if (avs_read) m_rd = reg_model(avs_address);
    set_v = '0;
    for (int b = 0; b < IW; b++) begin
      // A change of the debounced level counts if its direction matches the polarity bit.
      if (m_stable[b] != m_prev[b]) set_v[b] = m_stable[b] ? !m_pol[b] : m_pol[b];
    end
`ifdef PIO_IRQ_TSTAMP_EN
    if (m_cap == '0 && set_v != '0) m_ts = m_cnt;
`endif
    m_cnt = m_cnt + 32'd1;
    m_irq = |(m_cap & m_mask);
    clr = (avs_write && avs_address == 3'd3) ? avs_writedata[IW-1:0] : '0;
    m_cap = (m_cap & ~clr) | set_v;
    if (avs_write) begin
      if (avs_address == 3'd1) m_out = avs_writedata[OW-1:0];
      if (avs_address == 3'd2) m_mask = avs_writedata[IW-1:0];
      if (avs_address == 3'd4) m_pol = avs_writedata[IW-1:0];
    end
    m_prev = m_stable;
    // New level accepted after DEB consecutive samples disagreeing with it.
    seen = m_pipe[SS-1];
    for (int b = 0; b < IW; b++) begin
      if (seen[b] != m_stable[b]) begin
        m_run[b]++;
        if (m_run[b] >= DEB) begin
          m_stable[b] = seen[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    for (int s = SS - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
    m_pipe[0] = sw;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] exp_ts;
    model_reset();

    // Reset state
    #23;
    chk("reset_leds", 32'(leds), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_readdata", avs_readdata, 32'h0);
    rst_n = 1'b1;

    // 1. Output register write and readback
    wr(3'd1, 32'h0000_000A);
    chk("leds_after_write", 32'(leds), 32'hA);
    rd(3'd1, r);
    chk("read_data_out", r, 32'hA);

    // 2. Glitch shorter than the debounce window is rejected
    sw[0] = 1'b1;
    ticks(3);
    sw[0] = 1'b0;
    ticks(10);
    rd(3'd0, r);
    chk("glitch_data_in", r, 32'h0);
    rd(3'd3, r);
    chk("glitch_edge_cap", r, 32'h0);

    // 3. Pin-to-irq latency and W1C deassertion
    wr(3'd2, 32'h1);
    sw[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) chk("irq_before_latency", 32'(irq), 32'h0);
      if (i == 8) chk("irq_at_latency", 32'(irq), 32'h1);
    end
    rd(3'd3, r);
    chk("edge_cap_bit0", r, 32'h1);
    wr(3'd3, 32'h1);
    chk("irq_same_cycle_as_clear", 32'(irq), 32'h1);
    tick();
    chk("irq_after_clear", 32'(irq), 32'h0);

    // 4. Falling polarity on bit1, masked then unmasked
    wr(3'd2, 32'h0);
    wr(3'd4, 32'h2);
    sw[1] = 1'b1;
    ticks(10);
    rd(3'd3, r);
    chk("rising_ignored_pol1", r, 32'h0);
    sw[1] = 1'b0;
    ticks(10);
    rd(3'd3, r);
    chk("falling_captured_pol1", r, 32'h2);
    chk("irq_masked", 32'(irq), 32'h0);
    wr(3'd2, 32'h2);
    chk("irq_mask_write_edge", 32'(irq), 32'h0);
    tick();
    chk("irq_after_mask_write", 32'(irq), 32'h1);
    wr(3'd3, 32'hF);
    wr(3'd2, 32'h0);

    // 5. W1C in the same cycle as a new capture: set wins
    sw[0] = 1'b0;
    ticks(10);
    sw[0] = 1'b1;
    ticks(6);
    wr(3'd3, 32'h1);
    rd(3'd3, r);
    chk("set_wins_over_w1c", r, 32'h1);
    wr(3'd3, 32'hF);

    // 6. Timestamp of the first edge, held across a second edge
    exp_ts = m_cnt + 32'd6;
    sw[2] = 1'b1;
    ticks(10);
    sw[3] = 1'b1;
    ticks(10);
    rd(3'd5, r);
`ifdef PIO_IRQ_TSTAMP_EN
    chk("tstamp_first_edge", r, exp_ts);
`else
    chk("tstamp_absent", r, 32'h0);
`endif
    rd(3'd3, r);
    chk("edge_cap_bits23", r, 32'hC);
    rd(3'd0, r);
    chk("data_in_level", r, 32'hD);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, r);
    chk("addr6_reads_zero", r, 32'h0);
    rd(3'd7, r);
    chk("addr7_reads_zero", r, 32'h0);

    // Asynchronous reset mid-debounce
    wr(3'd2, 32'hF);
    tick();
    chk("irq_before_reset", 32'(irq), 32'h1);
    sw[3] = 1'b0;
    ticks(2);
    rd(3'd1, r);
    chk("readdata_before_reset", r, 32'hA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_leds", 32'(leds), 32'h0);
    chk("async_reset_irq", 32'(irq), 32'h0);
    chk("async_reset_readdata", avs_readdata, 32'h0);
    #2;
    rst_n = 1'b1;
    model_reset();
    rd(3'd0, r);
    chk("data_in_after_reset", r, 32'h0);

    // Randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) sw[$urandom_range(0, IW - 1)] ^= 1'b1;
      avs_write = 1'b0;
      avs_read = 1'b0;
      case ($urandom_range(0, 7))
        0, 1: begin
          avs_write = 1'b1;
          avs_address = 3'($urandom_range(0, 7));
          avs_writedata = $urandom;
        end
        2, 3, 4: begin
          avs_read = 1'b1;
          avs_address = 3'($urandom_range(0, 7));
        end
        default: ;
      endcase
      tick();
      chk("rand_leds", 32'(leds), 32'(m_out));
      chk("rand_irq", 32'(irq), 32'(m_irq));
      chk("rand_readdata", avs_readdata, m_rd);
    end
    avs_write = 1'b0;
    avs_read = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pio_irq_ctrl.md
Name: pio_irq_ctrl

Overview:
Parametrised general-purpose I/O peripheral with an Avalon-MM slave. It is the successor to the fixed 4-bit LED/switch PIO pair.
- Drives OUT_WIDTH output pins (LEDs).
- Synchronises and debounces IN_WIDTH input pins (switches/keys).
- Captures per-bit edges of configurable polarity and raises a maskable level interrupt to the HPS.
- Sits on the lightweight HPS-to-FPGA bridge, alongside the SDRAM/HPS subsystem.

Parameters:
IN_WIDTH, 4, number of input pins (1..32)
OUT_WIDTH, 4, number of output pins (1..32)
SYNC_STAGES, 2, input synchroniser flops (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new input level (>=1)
OUT_RESET_VAL, 0, reset value of the output register

Ports:
clk_clk  input  1  system clock; only clock in the block
reset_reset_n  input  1  asynchronous active-low reset
avs_address  input  3  word address
avs_read  input  1  read strobe
avs_write  input  1  write strobe
avs_writedata  input  32  write data
avs_readdata  output  32  read data, valid 1 cycle after avs_read
irq  output  1  level interrupt, active high
switches_export  input  IN_WIDTH  raw asynchronous inputs
leds_export  output  OUT_WIDTH  output pins

Behaviour:
- Reset values: leds_export=OUT_RESET_VAL; avs_readdata=0; irq=0; all registers 0; debounced state=0; synchroniser flops=0.
- Register map (word address):
  - 0 DATA_IN (RO, debounced inputs)
  - 1 DATA_OUT (RW)
  - 2 IRQ_MASK (RW)
  - 3 EDGE_CAP (read; write-1-to-clear)
  - 4 EDGE_POL (RW; bit=0 rising, 1 falling)
  - 5 TSTAMP (see Optional Feature)
  - 6-7 read 0, writes ignored
- Register bits above IN_WIDTH/OUT_WIDTH read 0; writes to them are ignored.
- Slave timing: zero wait states. Write takes effect at the clock edge where avs_write=1. Read data is registered: avs_readdata is valid in the cycle after avs_read. avs_readdata holds its value when avs_read=0.
- Input path, per bit: SYNC_STAGES flop chain, then debounce counter.
  - Counter is width clog2(DEBOUNCE_CYCLES+1).
  - Synced value equal to stable value: counter resets to 0.
  - Synced value differs: counter increments.
  - Counter reaches DEBOUNCE_CYCLES-1 while the value still differs: stable bit toggles next edge and counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the stable bit.
- Edge detect: compares the stable value against its previous-cycle copy. A qualifying edge per EDGE_POL sets the EDGE_CAP bit on the next edge.
- Simultaneous W1C and new edge on the same bit: the set wins, so the bit stays 1.
- irq is registered: irq <= |(EDGE_CAP & IRQ_MASK). irq rises 1 cycle after the EDGE_CAP bit is set or the mask is written.
- irq deasserts 1 cycle after the last masked bit is cleared. Changing EDGE_POL does not generate edges.
- Latency, pin change to irq: SYNC_STAGES + DEBOUNCE_CYCLES + 2 cycles.
- Reset asserted mid-operation: all state clears immediately (asynchronous); debounce restarts from 0.

Optional Feature:
Macro PIO_IRQ_TSTAMP_EN.
- Defined:
  - 32-bit free-running cycle counter, wraps 0xFFFFFFFF->0.
  - When any EDGE_CAP bit sets while EDGE_CAP was all-zero, the counter value of that cycle is latched into TSTAMP.
  - Further edges do not update TSTAMP until EDGE_CAP returns to all-zero.
  - TSTAMP is read-only.
- Undefined: no counter logic; address 5 reads 0.

Decomposition:
- Shared package pio_irq_pkg holds:
  - address constants: ADDR_DATA_IN=0, ADDR_DATA_OUT=1, ADDR_IRQ_MASK=2, ADDR_EDGE_CAP=3, ADDR_EDGE_POL=4, ADDR_TSTAMP=5
  - typedef for the 3-bit register address
- Sub-module pio_debounce: one bit wide, parameters SYNC_STAGES and DEBOUNCE_CYCLES. Instantiated IN_WIDTH times in a generate loop. Outputs the stable level.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, IN_WIDTH=OUT_WIDTH=4.
1. Reset, then write 0xA to address 1 → leds_export=0xA next cycle; read address 1 → readdata=0xA one cycle after read.
2. switches_export bit0 high for 3 cycles then low → DATA_IN stays 0 and EDGE_CAP stays 0 (glitch rejected).
3. Mask=0x1, bit0 held high → EDGE_CAP=0x1 and irq=1 exactly 2+4+2=8 cycles after the pin change; write 0x1 to address 3 → irq=0 one cycle later.
4. EDGE_POL=0x2, bit1 rising then falling → only the falling edge sets EDGE_CAP[1]; with mask=0 irq stays 0, and writing mask=0x2 raises irq the next cycle.
5. W1C of bit0 issued in the same cycle the bit0 edge is captured → EDGE_CAP[0] reads 1 afterwards.
6. With PIO_IRQ_TSTAMP_EN: first edge at counter=N → address 5 reads N; a second edge before clearing leaves it at N. Assert reset_reset_n=0 mid-debounce → all outputs 0 asynchronously.
